// File: rtl/red_pkg.sv
// Shared types for the Red decode/execute stage.
// Opcode/state enums and instruction field positions.
package red_pkg;

  localparam int NUM_REGS = 16;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_BR   = 4'h4,
    OP_BZ   = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_MUL  = 4'h9,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_EXEC,
    S_BR_TGT,
    S_SKIP,
    S_FLUSH,
    S_MUL,
    S_HALT
  } state_e;

endpackage

// File: rtl/red_decode_if.sv
// Fetch <-> decode link: enable, opcode word, branch request, fetch enable.
// master = fetch side, slave = decode side.
interface red_decode_if;
  logic        en;
  logic [15:0] opcode;
  logic        br;
  logic        fetch_en;

  modport master (
    output en, opcode,
    input  br, fetch_en
  );

  modport slave (
    input  en, opcode,
    output br, fetch_en
  );
endinterface

// File: rtl/red_mul.sv
// Iterative shift-add multiplier, one partial product per enabled cycle.
// done is high on the last iteration; p_o then holds the final low product.
module red_mul #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] p_o
);
  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
  logic [DATA_W-1:0] acc_d;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;

  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = busy_q & (cnt_q == CW'(DATA_W - 1));
  assign busy_o = busy_q;
  assign p_o    = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (en_i) begin
      if (start_i) begin
        acc_q    <= '0;
        mcand_q  <= a_i;
        mplier_q <= b_i;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (done_o) busy_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/red_decode.sv
// Red decode/execute stage: 16x16 register file, ALU, branch/flush control.
// Define RED_DECODE_MUL_EN to add the iterative MUL instruction (op 9).
module red_decode
  import red_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic              clk,
  input  logic              rst,
  red_decode_if.slave       fif,
  output logic              halted,
  output logic              flag_z,
  input  logic [3:0]        dbg_rsel,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic              flag_q, flag_d;
  logic [1:0]        fcnt_q, fcnt_d;

  logic [3:0]        op, rd, rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] a, b;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign op  = fif.opcode[OP_HI:OP_LO];
  assign rd  = fif.opcode[RD_HI:RD_LO];
  assign rs  = fif.opcode[RS_HI:RS_LO];
  assign imm = fif.opcode[IMM_HI:IMM_LO];
  assign a   = rf_q[rd];
  assign b   = rf_q[rs];

`ifdef RED_DECODE_MUL_EN
  logic              mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_p;
  logic [3:0]        mrd_q;

  red_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .en_i    (fif.en),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  // Destination is latched because the opcode bus already shows the next word.
  always_ff @(posedge clk) begin
    if (rst)            mrd_q <= '0;
    else if (mul_start) mrd_q <= rd;
  end
`endif

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    fcnt_d  = fcnt_q;
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = '0;
`ifdef RED_DECODE_MUL_EN
    mul_start = 1'b0;
`endif
    if (fif.en) begin
      unique case (state_q)
        S_EXEC: begin
          case (op)
            OP_LDI: begin
              wr_en   = 1'b1;
              wr_data = {{(DATA_W-8){1'b0}}, imm};
            end
            OP_ADD: begin wr_en = 1'b1; wr_data = a + b; end
            OP_SUB: begin wr_en = 1'b1; wr_data = a - b; end
            OP_AND: begin wr_en = 1'b1; wr_data = a & b; end
            OP_OR:  begin wr_en = 1'b1; wr_data = a | b; end
            OP_XOR: begin wr_en = 1'b1; wr_data = a ^ b; end
            OP_BR:  state_d = S_BR_TGT;
            OP_BZ:  state_d = flag_q ? S_BR_TGT : S_SKIP;
`ifdef RED_DECODE_MUL_EN
            OP_MUL: begin
              state_d   = S_MUL;
              mul_start = 1'b1;
            end
`endif
            OP_HALT: state_d = S_HALT;
            default: ;
          endcase
        end
        S_BR_TGT: begin
          if (FLUSH_SLOTS == 0) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_FLUSH;
            fcnt_d  = 2'(FLUSH_SLOTS);
          end
        end
        S_SKIP: state_d = S_EXEC;
        S_FLUSH: begin
          if (fcnt_q <= 2'd1) begin
            state_d = S_EXEC;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        S_MUL: begin
`ifdef RED_DECODE_MUL_EN
          if (mul_done) begin
            wr_en   = 1'b1;
            wr_addr = mrd_q;
            wr_data = mul_p;
          end
          if (mul_done || !mul_busy) state_d = S_EXEC;
`else
          state_d = S_EXEC;
`endif
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_EXEC;
      endcase
    end
    if (wr_en) flag_d = (wr_data == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EXEC;
      flag_q  <= 1'b0;
      fcnt_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      fcnt_q  <= fcnt_d;
      if (wr_en) rf_q[wr_addr] <= wr_data;
    end
  end

  assign fif.br       = fif.en & (state_q == S_BR_TGT);
  assign fif.fetch_en = !((state_q == S_MUL) || (state_q == S_HALT));
  assign halted       = (state_q == S_HALT);
  assign flag_z       = flag_q;
  assign dbg_rdata    = rf_q[dbg_rsel];

endmodule

// File: tb/tb_red_decode.sv
// Directed testbench for red_decode.
// Acts as the fetch stage, driving opcode words and checking via the debug port.
module tb_red_decode;
  import red_pkg::*;

  localparam int FS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        halted;
  logic        flag_z;
  logic [3:0]  dbg_rsel;
  logic [15:0] dbg_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  red_decode_if fif();

  red_decode #(
    .DATA_W      (16),
    .FLUSH_SLOTS (FS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fif       (fif),
    .halted    (halted),
    .flag_z    (flag_z),
    .dbg_rsel  (dbg_rsel),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] w);
    fif.opcode = w;
    step();
  endtask

  task automatic peek(input logic [3:0] r);
    dbg_rsel = r;
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    fif.en     = 1'b1;
    fif.opcode = 16'h0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fif.opcode = 16'h1FAA;
    do_reset();
    n_chk++;
    if (fif.br !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_br got %b exp 0", fif.br);
    end
    n_chk++;
    if (fif.fetch_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fetch_en got %b exp 1", fif.fetch_en);
    end
    n_chk++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_halted got %b exp 0", halted);
    end
    n_chk++;
    if (flag_z !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flag_z got %b exp 0", flag_z);
    end
    peek(4'd15);
    n_chk++;
    if (dbg_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_r15 got %h exp 0000", dbg_rdata);
    end
  endtask

  task automatic test_alu();
    logic [15:0] w [16] = '{
      16'h1105, 16'h1203, 16'h2120, 16'h3110,
      16'h110C, 16'h120A, 16'h6120, 16'h7120,
      16'h8120, 16'h1300, 16'h1401, 16'h3340,
      16'h2340, 16'h0000, 16'h2440, 16'hA120
    };
    logic [3:0] r [16] = '{
      4'd1, 4'd2, 4'd1, 4'd1,
      4'd1, 4'd2, 4'd1, 4'd1,
      4'd1, 4'd3, 4'd4, 4'd3,
      4'd3, 4'd3, 4'd4, 4'd1
    };
    logic [15:0] ev [16] = '{
      16'h0005, 16'h0003, 16'h0008, 16'h0000,
      16'h000C, 16'h000A, 16'h0008, 16'h000A,
      16'h0000, 16'h0000, 16'h0001, 16'hFFFF,
      16'h0000, 16'h0000, 16'h0002, 16'h0000
    };
    logic ez [16] = '{
      1'b0, 1'b0, 1'b0, 1'b1,
      1'b0, 1'b0, 1'b0, 1'b0,
      1'b1, 1'b1, 1'b0, 1'b0,
      1'b1, 1'b1, 1'b0, 1'b0
    };
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(w[i]);
      peek(r[i]);
      n_chk++;
      if (dbg_rdata !== ev[i]) begin
        n_fail++;
        $display("FAIL alu_%0d_data op %h got %h exp %h",
                 i, w[i], dbg_rdata, ev[i]);
      end
      n_chk++;
      if (flag_z !== ez[i]) begin
        n_fail++;
        $display("FAIL alu_%0d_flag op %h got %b exp %b",
                 i, w[i], flag_z, ez[i]);
      end
    end
  endtask

  task automatic test_branch();
    int brc;
    do_reset();
    issue(16'h4000);
    fif.opcode = 16'h0020;
    #1;
    n_chk++;
    if (fif.br !== 1'b1) begin
      n_fail++;
      $display("FAIL br_high got %b exp 1", fif.br);
    end
    step();
    brc = 0;
    for (int i = 0; i < FS; i++) begin
      fif.opcode = 16'h1FFF;
      #1;
      if (fif.br) brc++;
      step();
    end
    n_chk++;
    if (brc != 0) begin
      n_fail++;
      $display("FAIL br_one_cycle got %0d extra exp 0", brc);
    end
    peek(4'd15);
    n_chk++;
    if (dbg_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL br_flush_r15 got %h exp 0000", dbg_rdata);
    end
    issue(16'h1511);
    peek(4'd5);
    n_chk++;
    if (dbg_rdata !== 16'h0011) begin
      n_fail++;
      $display("FAIL br_resume_r5 got %h exp 0011", dbg_rdata);
    end
  endtask

  task automatic test_bz_taken();
    do_reset();
    issue(16'h3110);
    issue(16'h5000);
    fif.opcode = 16'h0030;
    #1;
    n_chk++;
    if (fif.br !== 1'b1) begin
      n_fail++;
      $display("FAIL bz_taken_br got %b exp 1", fif.br);
    end
    step();
    for (int i = 0; i < FS; i++) issue(16'h1FFF);
    issue(16'h1633);
    peek(4'd15);
    n_chk++;
    if (dbg_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL bz_taken_r15 got %h exp 0000", dbg_rdata);
    end
    peek(4'd6);
    n_chk++;
    if (dbg_rdata !== 16'h0033) begin
      n_fail++;
      $display("FAIL bz_taken_r6 got %h exp 0033", dbg_rdata);
    end
  endtask

  task automatic test_bz_not_taken();
    int brc;
    do_reset();
    issue(16'h1301);
    issue(16'h5000);
    brc = 0;
    fif.opcode = 16'h0040;
    #1;
    if (fif.br) brc++;
    step();
    fif.opcode = 16'h1307;
    #1;
    if (fif.br) brc++;
    step();
    n_chk++;
    if (brc != 0) begin
      n_fail++;
      $display("FAIL bz_nt_br got %0d high cycles exp 0", brc);
    end
    peek(4'd3);
    n_chk++;
    if (dbg_rdata !== 16'h0007) begin
      n_fail++;
      $display("FAIL bz_nt_r3 got %h exp 0007", dbg_rdata);
    end
  endtask

  task automatic test_en_hold();
    do_reset();
    fif.en     = 1'b0;
    fif.opcode = 16'h1744;
    step();
    step();
    peek(4'd7);
    n_chk++;
    if (dbg_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL en_low_r7 got %h exp 0000", dbg_rdata);
    end
    fif.en = 1'b1;
    issue(16'h4000);
    fif.en     = 1'b0;
    fif.opcode = 16'h0020;
    #1;
    n_chk++;
    if (fif.br !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low_br got %b exp 0", fif.br);
    end
    step();
    step();
    step();
    fif.en = 1'b1;
    #1;
    n_chk++;
    if (fif.br !== 1'b1) begin
      n_fail++;
      $display("FAIL en_held_br got %b exp 1", fif.br);
    end
    step();
    for (int i = 0; i < FS; i++) issue(16'h1FFF);
    issue(16'h1522);
    peek(4'd5);
    n_chk++;
    if (dbg_rdata !== 16'h0022) begin
      n_fail++;
      $display("FAIL en_resume_r5 got %h exp 0022", dbg_rdata);
    end
  endtask

  task automatic test_halt();
    do_reset();
    issue(16'hF000);
    n_chk++;
    if (halted !== 1'b1 || fif.fetch_en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter got halted=%b fetch_en=%b exp 1/0",
               halted, fif.fetch_en);
    end
    issue(16'h1409);
    issue(16'h1409);
    issue(16'h1409);
    peek(4'd4);
    n_chk++;
    if (dbg_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL halt_r4 got %h exp 0000", dbg_rdata);
    end
    n_chk++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_sticky got %b exp 1", halted);
    end
    do_reset();
    n_chk++;
    if (halted !== 1'b0 || fif.fetch_en !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_exit got halted=%b fetch_en=%b exp 0/1",
               halted, fif.fetch_en);
    end
  endtask

  task automatic load_mul_operands();
    issue(16'h1280);
    issue(16'h2220);
    issue(16'h1101);
    issue(16'h2120);
  endtask

  task automatic test_mul();
    int lowc;
    int exp_low;
    logic [15:0] exp_r1;
    do_reset();
    load_mul_operands();
    peek(4'd1);
    n_chk++;
    if (dbg_rdata !== 16'h0101) begin
      n_fail++;
      $display("FAIL mul_setup_r1 got %h exp 0101", dbg_rdata);
    end
`ifdef RED_DECODE_MUL_EN
    exp_low = 16;
    exp_r1  = 16'h0100;
`else
    exp_low = 0;
    exp_r1  = 16'h0101;
`endif
    issue(16'h9120);
    fif.opcode = 16'h1307;
    lowc = 0;
    while (fif.fetch_en !== 1'b1 && lowc < 40) begin
      lowc++;
      step();
    end
    n_chk++;
    if (lowc != exp_low) begin
      n_fail++;
      $display("FAIL mul_fetch_en_low got %0d cycles exp %0d", lowc, exp_low);
    end
    issue(16'h1307);
    peek(4'd1);
    n_chk++;
    if (dbg_rdata !== exp_r1) begin
      n_fail++;
      $display("FAIL mul_r1 got %h exp %h", dbg_rdata, exp_r1);
    end
    peek(4'd3);
    n_chk++;
    if (dbg_rdata !== 16'h0007) begin
      n_fail++;
      $display("FAIL mul_next_ldi_r3 got %h exp 0007", dbg_rdata);
    end
    n_chk++;
    if (flag_z !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_flag got %b exp 0", flag_z);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    load_mul_operands();
    issue(16'h9120);
    fif.opcode = 16'h0000;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    peek(4'd1);
    n_chk++;
    if (fif.fetch_en !== 1'b1 || halted !== 1'b0 || flag_z !== 1'b0 ||
        fif.br !== 1'b0 || dbg_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mid_mul got fe=%b h=%b z=%b br=%b r1=%h exp 1/0/0/0/0000",
               fif.fetch_en, halted, flag_z, fif.br, dbg_rdata);
    end
    issue(16'h1555);
    peek(4'd5);
    n_chk++;
    if (dbg_rdata !== 16'h0055) begin
      n_fail++;
      $display("FAIL rst_mid_mul_resume got %h exp 0055", dbg_rdata);
    end
    issue(16'h3110);
    issue(16'h4000);
    issue(16'h0020);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (flag_z !== 1'b0 || fif.br !== 1'b0 || fif.fetch_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_flush got z=%b br=%b fe=%b exp 0/0/1",
               flag_z, fif.br, fif.fetch_en);
    end
    issue(16'h1566);
    peek(4'd5);
    n_chk++;
    if (dbg_rdata !== 16'h0066) begin
      n_fail++;
      $display("FAIL rst_mid_flush_resume got %h exp 0066", dbg_rdata);
    end
  endtask

  initial begin
    rst        = 1'b0;
    fif.en     = 1'b1;
    fif.opcode = 16'h0000;
    dbg_rsel   = 4'd0;
    test_reset();
    test_alu();
    test_branch();
    test_bz_taken();
    test_bz_not_taken();
    test_en_hold();
    test_halt();
    test_mul();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
